// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with a
// down-counter and raises the D-stage stall for MDU-class instructions.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDU_op,
    input  logic        start,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mdu_D,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        stall
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // 64-bit product; signed operands are sign-extended so the low 64 bits
    // of the unsigned product equal the two's-complement signed product.
    function automatic logic [63:0] mul_fn(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; zero divisor yields zeros (never written).
    function automatic logic [63:0] div_fn(input logic is_signed,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        q  = 32'd0;
        r  = 32'd0;
        if (b != 32'd0) begin
            if (is_signed) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {r, q};
    endfunction

    logic [3:0]  cnt_q,     cnt_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic [31:0] temp_hi_q, temp_hi_d;
    logic [31:0] temp_lo_q, temp_lo_d;
    logic        dz_q,      dz_d;

    logic [63:0] mul_res;
    logic [63:0] div_res;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
            dz_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        mul_res   = mul_fn(MDU_op == OP_MULT, rs_data, rt_data);
        div_res   = div_fn(MDU_op == OP_DIV, rs_data, rt_data);
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        dz_d      = dz_q;
        if (cnt_q != 4'd0) begin
            // RUN: new ops are ignored; results land on the final edge
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && !dz_q) begin
                hi_d = temp_hi_q;
                lo_d = temp_lo_q;
            end
        end else if (start) begin
            case (MDU_op)
                OP_MULT, OP_MULTU: begin
                    temp_hi_d = mul_res[63:32];
                    temp_lo_d = mul_res[31:0];
                    dz_d      = 1'b0;
                    cnt_d     = 4'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    temp_hi_d = div_res[63:32];
                    temp_lo_d = div_res[31:0];
                    dz_d      = (rt_data == 32'd0);
                    cnt_d     = 4'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = rs_data;
                OP_MTLO: lo_d = rs_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy  = (cnt_q != 4'd0);
        stall = mdu_D & (busy | (start & (MDU_op >= OP_MULT) & (MDU_op <= OP_DIVU)));
        HI    = hi_q;
        LO    = lo_q;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit and its sequencer for the P6 five-stage MIPS pipeline. The block sits in the E stage and accepts mult/multu/div/divu/mthi/mtlo from the MDU_op decode field. It owns the HI/LO registers and models multi-cycle latency with a busy counter. It generates the D-stage stall for any MDU-class instruction (md/mf/mt) that arrives while an operation is pending.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk edge
MDU_op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
start  input  1  E-stage qualifier; an op is accepted only when start=1
rs_data  input  32  forwarded rs value (dividend / multiplicand / mt source)
rt_data  input  32  forwarded rt value (divisor / multiplier)
mdu_D  input  1  D-stage instruction is md, mf or mt class
HI  output  32  HI register
LO  output  32  LO register
busy  output  1  operation in progress
stall  output  1  freeze PC/F/D, bubble into E

Behaviour:
- Reset (reset=0 at an edge): HI=0, LO=0, cnt=0, busy=0, temp_hi=0, temp_lo=0; any in-flight operation is discarded without writing HI/LO.
- State is a 4-bit down-counter cnt. IDLE when cnt==0; RUN otherwise. busy = (cnt!=0).
- Accept condition: start=1, busy=0, MDU_op in 1..6.
- mult/multu accepted at edge E0: compute the 64-bit product (signed for op 1, unsigned for op 2) into temp_hi/temp_lo; cnt<=MULT_CYCLES.
- div/divu accepted at edge E0: quotient goes to temp_lo and remainder to temp_hi; cnt<=DIV_CYCLES.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor==0 (div or divu): the op is accepted and busy runs the full DIV_CYCLES, but HI/LO are not written at completion.
- RUN: cnt decrements by 1 each edge. At the edge where cnt==1, HI<=temp_hi, LO<=temp_lo (unless the op was a divide-by-zero), and cnt becomes 0.
- Timing: busy is high for exactly N cycles after E0, and new HI/LO are visible in the cycle busy first reads 0.
- mthi/mtlo accepted: HI (or LO) <= rs_data at the same edge; no busy; the other register is unchanged.
- start=1 while busy=1: the op is ignored (no state change). The stall logic guarantees this never occurs in normal flow; the bench checks it anyway.
- HI/LO are readable combinationally at all times. They hold the old value until the completion edge.
- stall = mdu_D & (busy | (start & MDU_op in 1..4)). This covers both the in-flight op and the op being accepted this cycle.
- No stall is raised for non-MDU D instructions; independent instructions proceed under a running op.
- Reset has priority over start and over the completion write.

Test Plan:
- mult: rs=0xFFFFFFFD(-3), rt=5, start 1 cycle -> busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO unchanged (0) while busy.
- multu: rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div signed and divu edge cases:
  - div rs=0xFFFFFFF9(-7), rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu 7/0 -> busy 10 cycles, HI/LO keep their prior values.
- Stall: start div, then hold mdu_D=1 -> stall=1 in the start cycle and all 10 busy cycles, 0 in the cycle after busy falls.
  - mdu_D=0 during busy -> stall=0.
  - start mult while busy -> ignored, HI/LO and cnt unaffected.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 -> HI/LO updated on the next edge, busy stays 0, no stall.
- Reset mid-op: start mult, assert reset=0 on busy cycle 2 -> next edge HI=LO=0, busy=0, no later write.
  - Asserting reset with start=1 also wins.
